// File: rtl/wb_conbus_pkg.sv
// Shared constants, FSM encoding and width helper for the Wishbone interconnect.
package wb_conbus_pkg;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Ceiling log2, never less than 1 so single-entry indices keep a real bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_conbus_rr_arbiter.sv
// Round-robin search: first requester after the last winner, wrapping modulo N.
module rr_arbiter
    import wb_conbus_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [N-1:0]     grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    // Scan last+1 .. last+N; explicit wrap keeps non-power-of-two N correct.
    always_comb begin
        int unsigned cand;
        valid_o     = 1'b0;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(last_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o                   = 1'b1;
                grant_idx_o               = IDX_W'(cand);
                grant_oh_o[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_conbus_rr.sv
// Multi-master Wishbone interconnect with round-robin arbitration, address
// decode, unmapped-address error and a stall watchdog.
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int unsigned                     NUM_MASTERS = 2,
    parameter int unsigned                     NUM_SLAVES  = 6,
    parameter int unsigned                     S_ADDR_W    = 4,
    parameter logic [NUM_SLAVES*S_ADDR_W-1:0]  S_BASE      = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
    parameter int unsigned                     TIMEOUT     = 255
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [NUM_MASTERS*WB_DW-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*WB_DW-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*WB_SW-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    output logic [WB_DW-1:0]              m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    input  logic [NUM_SLAVES*WB_DW-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]         s_ack_i,
    output logic [WB_DW-1:0]              s_dat_o,
    output logic [WB_DW-1:0]              s_adr_o,
    output logic [WB_SW-1:0]              s_sel_o,
    output logic                          s_we_o,
    output logic [NUM_SLAVES-1:0]         s_cyc_o,
    output logic [NUM_SLAVES-1:0]         s_stb_o
);

    localparam int unsigned GW  = clog2_min1(NUM_MASTERS);
    localparam int unsigned WW  = clog2_min1(TIMEOUT + 1);
    localparam int unsigned SIW = clog2_min1(NUM_SLAVES);

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [NUM_MASTERS-1:0] grant_oh_q, grant_oh_d;
    logic [GW-1:0]          last_q, last_d;
    logic [WW-1:0]          wdog_q, wdog_d;
    logic                   err_q, err_d;

    logic                   arb_valid;
    logic [NUM_MASTERS-1:0] arb_oh;
    logic [GW-1:0]          arb_idx;

    logic                   busy;
    logic                   g_cyc, g_stb, g_we;
    logic [WB_DW-1:0]       g_adr, g_dat;
    logic [WB_SW-1:0]       g_sel;

    logic                   hit;
    logic [SIW-1:0]         sidx;
    logic [NUM_SLAVES-1:0]  s_oh;
    logic                   slave_ack;

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (GW)
    ) u_arb (
        .req_i       (m_cyc_i),
        .last_i      (last_q),
        .valid_o     (arb_valid),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx)
    );

    // Select the granted master's request; everything reads as idle outside BUSY.
    always_comb begin
        busy  = (state_q == BUSY);
        g_cyc = busy & m_cyc_i[grant_q];
        g_stb = busy & m_stb_i[grant_q];
        g_we  = busy & m_we_i[grant_q];
        g_adr = busy ? m_adr_i[32'(grant_q)*WB_DW +: WB_DW] : '0;
        g_dat = busy ? m_dat_i[32'(grant_q)*WB_DW +: WB_DW] : '0;
        g_sel = busy ? m_sel_i[32'(grant_q)*WB_SW +: WB_SW] : '0;
    end

    // Address decode on the top S_ADDR_W bits; lowest matching slot wins.
    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        s_oh = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && (g_adr[WB_DW-1 -: S_ADDR_W] == S_BASE[i*S_ADDR_W +: S_ADDR_W])) begin
                hit     = 1'b1;
                sidx    = SIW'(i);
                s_oh[i] = 1'b1;
            end
        end
        slave_ack = busy & hit & s_ack_i[sidx];
    end

    // Bus outputs: broadcast request fields, per-slave cyc/stb, grant-gated responses.
    always_comb begin
        s_dat_o = g_dat;
        s_adr_o = g_adr;
        s_sel_o = g_sel;
        s_we_o  = g_we;
        s_cyc_o = {NUM_SLAVES{g_cyc}} & s_oh;
        s_stb_o = {NUM_SLAVES{g_stb}} & s_oh;
        m_dat_o = (busy && hit) ? s_dat_i[32'(sidx)*WB_DW +: WB_DW] : '0;
        m_ack_o = (slave_ack && !err_q) ? grant_oh_q : '0;
        m_err_o = err_q ? grant_oh_q : '0;
    end

    // Next-state: arbitration in IDLE, release/error/watchdog handling in BUSY.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        last_d     = last_q;
        wdog_d     = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = BUSY;
                    grant_d    = arb_idx;
                    grant_oh_d = arb_oh;
                    last_d     = arb_idx;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d    = IDLE;
                    grant_oh_d = '0;
                end else if (g_stb) begin
                    if (!hit) begin
                        err_d = !err_q;
                    end else if (!slave_ack && (TIMEOUT != 0)) begin
                        if (wdog_q == WW'(TIMEOUT - 1)) begin
                            err_d = 1'b1;
                        end else begin
                            wdog_d = wdog_q + WW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            last_q     <= GW'(NUM_MASTERS - 1);
            wdog_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
        end
    end

endmodule
